// File: rtl/clk_div_pair.sv
// clk_div_pair
// ------------
// Programmable clock-phase generator. A base phase toggles every div_q cycles
// of clk, giving a 2*div_q cycle period. Each of the N_OUT outputs is that base
// phase XORed with its own inversion bit. A valid/ready configuration port
// loads the divisor and inversion mask. New values only take effect at a
// period boundary or while idle, so the generated clocks never glitch.
//
// Optional feature (macro CLK_DIV_PAIR_CFG_BUFFER_EN):
//   Adds a one-deep pending configuration slot. This lets a new configuration
//   be accepted while running. It is applied at the next period boundary, or
//   when the block drops back to idle. Without the macro, configuration is
//   only accepted while idle.
//
// Parameters:
//   WIDTH      width of the half-period divisor
//   N_OUT      number of generated clock outputs
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   en         run request (level)
//   cfg_valid  configuration offered
//   cfg_ready  configuration can be accepted this cycle (combinational)
//   cfg_div    half-period in clk cycles; 0 is treated as 1
//   cfg_inv    per-output inversion mask
//   div_clk    generated clocks (registered)
//   tick       one-cycle pulse in the first cycle of each high base phase
//   busy       high while not idle
module clk_div_pair #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [N_OUT-1:0] cfg_inv,
    output logic [N_OUT-1:0] div_clk,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t             state, state_n;
    logic               phase, phase_n;
    logic [WIDTH-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   div_q, div_n;
    logic [N_OUT-1:0]   inv_q, inv_n;
    logic               tick_n;
    logic               busy_n;
    logic [N_OUT-1:0]   div_clk_n;

    logic               accept;
    logic               last;
    logic               apply_edge;
    logic [WIDTH-1:0]   cfg_div_fix;

`ifdef CLK_DIV_PAIR_CFG_BUFFER_EN
    logic               pend_valid, pend_valid_n;
    logic [WIDTH-1:0]   pend_div, pend_div_n;
    logic [N_OUT-1:0]   pend_inv, pend_inv_n;

    // While running, the port stays open only as long as the pending slot is free.
    assign cfg_ready = (state == IDLE) || !pend_valid;
`else
    assign cfg_ready = (state == IDLE);
`endif

    assign accept      = cfg_valid && cfg_ready;
    assign cfg_div_fix = (cfg_div == '0) ? WIDTH'(1) : cfg_div;
    // div_q is never zero, so this subtraction cannot wrap.
    assign last        = (cnt == div_q - WIDTH'(1));

    // Next-state logic. apply_edge marks the edges where a new configuration
    // may become active: any accepting edge in IDLE, a period boundary
    // (phase 0->1) in RUN, and the final STOP->IDLE edge.
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        cnt_n      = cnt;
        div_n      = div_q;
        inv_n      = inv_q;
        tick_n     = 1'b0;
        apply_edge = 1'b0;
`ifdef CLK_DIV_PAIR_CFG_BUFFER_EN
        pend_valid_n = pend_valid;
        pend_div_n   = pend_div;
        pend_inv_n   = pend_inv;
`endif

        case (state)
            IDLE: begin
                apply_edge = 1'b1;
                if (en) begin
                    state_n = RUN;
                    phase_n = 1'b1;
                    cnt_n   = '0;
                    tick_n  = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    cnt_n   = '0;
                    phase_n = ~phase;
                    if (!phase) begin
                        tick_n     = 1'b1;
                        apply_edge = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                end
                if (!en) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                // The current period is always finished. The would-be
                // boundary becomes the return to IDLE instead.
                if (last) begin
                    cnt_n = '0;
                    if (!phase) begin
                        state_n    = IDLE;
                        phase_n    = 1'b0;
                        apply_edge = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = 1'b0;
                cnt_n   = '0;
            end
        endcase

        // A waiting pending config takes priority. Otherwise a transfer on an
        // apply edge is used directly. Off an apply edge, it is parked in the slot.
        if (apply_edge) begin
`ifdef CLK_DIV_PAIR_CFG_BUFFER_EN
            if (pend_valid) begin
                div_n        = pend_div;
                inv_n        = pend_inv;
                pend_valid_n = 1'b0;
            end else if (accept) begin
                div_n = cfg_div_fix;
                inv_n = cfg_inv;
            end
`else
            if (accept) begin
                div_n = cfg_div_fix;
                inv_n = cfg_inv;
            end
`endif
        end
`ifdef CLK_DIV_PAIR_CFG_BUFFER_EN
        else if (accept) begin
            pend_valid_n = 1'b1;
            pend_div_n   = cfg_div_fix;
            pend_inv_n   = cfg_inv;
        end
`endif

        // Outputs are registered from the next-state values, so they line up
        // with the state they describe.
        div_clk_n = {N_OUT{phase_n}} ^ inv_n;
        busy_n    = (state_n != IDLE);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase   <= 1'b0;
            cnt     <= '0;
            div_q   <= WIDTH'(1);
            inv_q   <= '0;
            tick    <= 1'b0;
            busy    <= 1'b0;
            div_clk <= '0;
`ifdef CLK_DIV_PAIR_CFG_BUFFER_EN
            pend_valid <= 1'b0;
            pend_div   <= WIDTH'(1);
            pend_inv   <= '0;
`endif
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            cnt     <= cnt_n;
            div_q   <= div_n;
            inv_q   <= inv_n;
            tick    <= tick_n;
            busy    <= busy_n;
            div_clk <= div_clk_n;
`ifdef CLK_DIV_PAIR_CFG_BUFFER_EN
            pend_valid <= pend_valid_n;
            pend_div   <= pend_div_n;
            pend_inv   <= pend_inv_n;
`endif
        end
    end

endmodule

// File: tb/tb_clk_div_pair.sv
// Testbench for clk_div_pair (WIDTH=8, N_OUT=2).
// Inputs are driven on the falling edge. At that point the reference model
// advances by one rising edge, and the expected post-edge outputs are queued.
// A monitor samples the DUT 1 time unit after each rising edge and compares
// its outputs against the queued entry. The model tracks the position inside
// the current period (0 .. 2*div-1) rather than a counter/phase pair.
// Compile with +define+CLK_DIV_PAIR_CFG_BUFFER_EN to exercise the pending slot.
module tb_clk_div_pair;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_div;
    logic [1:0] cfg_inv;
    logic [1:0] div_clk;
    logic       tick;
    logic       busy;

`ifdef CLK_DIV_PAIR_CFG_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    clk_div_pair #(.WIDTH(8), .N_OUT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_inv   (cfg_inv),
        .div_clk   (div_clk),
        .tick      (tick),
        .busy      (busy)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] clk_v;
        logic       tick_v;
        logic       busy_v;
        logic       ready_v;
    } exp_t;

    exp_t exp_q[$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: running/stopping flags, position within period,
    // active divisor/mask and the optional pending configuration.
    bit         m_run  = 1'b0;
    bit         m_stop = 1'b0;
    int         m_pos  = 0;
    int         m_div  = 1;
    logic [1:0] m_inv  = 2'b00;
    bit         m_tick = 1'b0;
    bit         m_pend = 1'b0;
    int         m_pdiv = 1;
    logic [1:0] m_pinv = 2'b00;

    // Compares one queued expectation against the sampled DUT outputs.
    task automatic checkOutput(input exp_t e);
        vectors++;
        if (div_clk !== e.clk_v) begin
            miscompares++;
            $display("[TB] FAIL div_clk at %0t: got %b, expected %b", $time, div_clk, e.clk_v);
        end
        vectors++;
        if (tick !== e.tick_v) begin
            miscompares++;
            $display("[TB] FAIL tick at %0t: got %b, expected %b", $time, tick, e.tick_v);
        end
        vectors++;
        if (busy !== e.busy_v) begin
            miscompares++;
            $display("[TB] FAIL busy at %0t: got %b, expected %b", $time, busy, e.busy_v);
        end
        vectors++;
        if (cfg_ready !== e.ready_v) begin
            miscompares++;
            $display("[TB] FAIL cfg_ready at %0t: got %b, expected %b", $time, cfg_ready, e.ready_v);
        end
    endtask

    // Drives one cycle of inputs, then advances the model across the
    // following rising edge and queues the expected outputs.
    task automatic applyStimulus(input logic r, input logic e, input logic v,
                                 input logic [7:0] d, input logic [1:0] iv);
        bit   active;
        bit   ready;
        bit   acc;
        int   nd;
        bit   phase;
        exp_t ex;
        @(negedge clk);
        rst_n     = r;
        en        = e;
        cfg_valid = v;
        cfg_div   = d;
        cfg_inv   = iv;

        active = m_run || m_stop;
        ready  = !active || (BUF && !m_pend);
        acc    = v && ready;
        nd     = (d == 8'd0) ? 1 : int'(d);

        if (!r) begin
            m_run = 0; m_stop = 0; m_pos = 0; m_div = 1; m_inv = 2'b00;
            m_pend = 0; m_tick = 0;
        end else if (!active) begin
            m_tick = 0;
            if (acc) begin m_div = nd; m_inv = iv; end
            if (e) begin m_run = 1; m_pos = 0; m_tick = 1; end
        end else begin
            m_tick = 0;
            m_pos++;
            if (m_pos == 2 * m_div) begin
                m_pos = 0;
                if (m_pend) begin
                    m_div = m_pdiv; m_inv = m_pinv; m_pend = 0;
                end else if (acc) begin
                    m_div = nd; m_inv = iv;
                end
                if (m_run) begin
                    m_tick = 1;
                    if (!e) begin m_run = 0; m_stop = 1; end
                end else begin
                    m_stop = 0;
                end
            end else begin
                if (acc) begin m_pend = 1; m_pdiv = nd; m_pinv = iv; end
                if (m_run && !e) begin m_run = 0; m_stop = 1; end
            end
        end

        phase      = (m_run || m_stop) && (m_pos < m_div);
        ex.clk_v   = {phase, phase} ^ m_inv;
        ex.tick_v  = m_tick;
        ex.busy_v  = m_run || m_stop;
        ex.ready_v = !(m_run || m_stop) || (BUF && !m_pend);
        exp_q.push_back(ex);
    endtask

    // Monitor: pops one expectation per rising edge once stimulus has begun.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic en_s;
        logic r;
        logic v;
        logic [7:0] d;
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0; cfg_inv = 2'b00;
        $display("[TB] starting clk_div_pair bench, buffer=%0d", BUF);

        // Reset, then div=3 inv=10 run
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd3, 2'b10);
        repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 2'b00);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 2'b00);

        // Divisor 0 coerced to 1
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd0, 2'b00);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 2'b00);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 2'b00);

        // div=4, drop en in the 2nd high cycle
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd4, 2'b01);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 2'b00);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 2'b00);

        // Reset mid high phase, then restart with div=1
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 2'b00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 2'b00);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 2'b00);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 2'b00);

        // Config offered while running with div=2
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 2'b00);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 2'b00);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b1, 8'd5, 2'b11);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b1, 8'd5, 2'b11);
        repeat (14) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 2'b00);

        // Randomized traffic
        en_s = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 29) == 0) en_s = ~en_s;
            v = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0)
                d = 8'($urandom_range(0, 40));
            else
                d = 8'($urandom_range(0, 5));
            applyStimulus(r, en_s, v, d, 2'($urandom_range(0, 3)));
        end

        // Let the monitor drain, then make sure nothing was left unchecked
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_pair.md
# clk_div_pair

Programmable clock-phase generator that produces `N_OUT` divided, per-output-invertible clock signals from the single `clk`. Its outputs feed the downstream consumer instances that take a `clk` input, including the inverted-phase consumer. A valid/ready configuration port sets the divisor and inversion mask. Changes take effect only on period boundaries, so the downstream clocks never glitch.

## Interface
- `WIDTH`, default 8: width of the half-period divisor.
- `N_OUT`, default 2: number of generated clock outputs.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  run request; level-sensitive.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted this cycle.
- `cfg_div`  in  WIDTH  half-period in `clk` cycles; 0 is coerced to 1 on acceptance.
- `cfg_inv`  in  N_OUT  per-output inversion mask.
- `div_clk`  out  N_OUT  generated clocks; `div_clk[i] = phase ^ inv_q[i]`.
- `tick`  out  1  one-cycle pulse in the first cycle of each high base phase.
- `busy`  out  1  high while not IDLE.

## Operation
- Registered state:
  - `state` ∈ {IDLE, RUN, STOP}
  - `phase`
  - `cnt[WIDTH]`
  - active `div_q`, `inv_q`
  - optional pending slot (see Configuration)
- Handshake:
  - A transfer occurs when `cfg_valid && cfg_ready` at an edge.
  - `cfg_valid` may drop without a transfer; nothing is latched in that case.
- IDLE:
  - `phase=0`, `cnt=0`, `cfg_ready=1`.
  - An accepted config loads `div_q`/`inv_q` directly.
  - If `en=1` at an edge: go to RUN with `phase<=1`, `cnt<=0`, `tick<=1`.
  - If `cfg` is accepted on that same edge, the new values govern the first period.
- RUN:
  - `cnt` increments each cycle.
  - When `cnt==div_q-1`: `cnt<=0`, `phase` toggles.
  - Period is `2*div_q` cycles.
  - Boundary = the edge where `phase` goes 0→1. At a boundary: `tick<=1`, and any pending config is applied to `div_q`/`inv_q`.
  - If `en=0` is sampled at any edge in RUN: go to STOP.
- STOP:
  - Counting continues until the low phase ends (the next would-be boundary).
  - At that edge go to IDLE: `phase` stays 0, no `tick`, and pending config is applied.
  - `en` re-asserted during STOP is ignored; the block returns to IDLE first, then restarts on the next edge with `en=1`.
- Inversion changes only at boundaries or in IDLE, so `div_clk` never changes mid-phase.
- Reset (any state, any cycle): `rst_n=0` at an edge forces:
  - IDLE, `phase=0`, `cnt=0`, `div_q=1`, `inv_q=0`
  - pending cleared, `tick=0`

## Timing
- Reset values: `div_clk=0`, `tick=0`, `busy=0`, `cfg_ready=1`.
- `div_clk`, `tick` and `busy` are registered. `cfg_ready` is combinational from state and pending.
- Start latency: `en` sampled high at edge k; `div_clk` base high and `tick=1` are visible after edge k.
- Each phase lasts exactly `div_q` cycles. `tick` is high for 1 cycle every `2*div_q` cycles.
- Stop latency: the block is IDLE at most `2*div_q` cycles after `en` is sampled low. The final period is always completed. `busy` falls with the IDLE transition.
- Divisor arithmetic: `cnt` compares against `div_q-1` in `WIDTH` bits. `div_q` is never 0, so wrap-around cannot occur.

## Configuration
- Macro: `CLK_DIV_PAIR_CFG_BUFFER_EN`.
- Defined:
  - One-deep pending slot.
  - In RUN/STOP, `cfg_ready=1` while the slot is empty.
  - A transfer fills the slot and `cfg_ready` drops until the slot is applied at the next boundary (or at the STOP→IDLE edge).
  - A transfer on a boundary edge with the slot empty is applied at that same boundary (bypass).
- Undefined:
  - No slot.
  - `cfg_ready=1` only in IDLE; `cfg_valid` in RUN/STOP is ignored.

## Test plan
- Reset, cfg `div=3`, `inv=2'b10`, `en=1`:
  - `div_clk[0]` is 3 high, 3 low, repeating.
  - `div_clk[1]` is its complement.
  - `tick` pulses every 6 cycles.
  - `busy=1`.
- `cfg_div=0`, `en=1`: period of 2 cycles, `tick` every 2 cycles.
- `div=4`, drop `en` in the 2nd cycle of a high phase:
  - 2 more high cycles, then 4 low cycles, then IDLE.
  - `busy=0`, `div_clk=inv_q`.
- (macro on) In RUN with `div=2`, send `div=5`:
  - `cfg_ready=0` until the next `tick`.
  - The following high phase lasts 5 cycles.
- `rst_n=0` for one edge mid high-phase:
  - Next cycle `div_clk=0`, `tick=0`, `busy=0`, `cfg_ready=1`.
  - After that, `en=1` restarts with `div=1`.
- (macro off) `cfg_valid=1` in RUN with `div=2`:
  - `cfg_ready=0` and the period remains 4.
  - The config is accepted once IDLE is reached.
